// File: rtl/serial_parity_rx.sv
// Odd-parity serial frame receiver: reassembles DATA_BITS data bits plus a trailing
// parity bit sampled on bit_en, pulses valid per completed frame, keeps saturating counters.
module serial_parity_rx #(
   parameter int DATA_BITS = 7,
   parameter int CNT_W     = 8
) (
   input  logic                 CLK100MHZ,
   input  logic                 reset,
   input  logic                 bit_en,
   input  logic                 sync,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 valid,
   output logic                 busy,
   output logic [CNT_W-1:0]     frame_count,
   output logic [CNT_W-1:0]     err_count
);

   localparam int BC_W = $clog2(DATA_BITS + 2);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS);

   logic [0:0]           state_reg,   state_next;
   logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS:0]   shift_reg,   shift_next;
   logic [DATA_BITS-1:0] data_reg,    data_next;
   logic                 perr_reg,    perr_next;
   logic                 valid_reg,   valid_next;
   logic [CNT_W-1:0]     fcnt_reg,    fcnt_next;
   logic [CNT_W-1:0]     ecnt_reg,    ecnt_next;

   // Shift register contents as they will be once the current serial_in is captured.
   logic [DATA_BITS:0]   shift_capture;
   logic                 parity_bad;

   assign shift_capture = {serial_in, shift_reg[DATA_BITS:1]};
   assign parity_bad    = (serial_in != ~^shift_capture[DATA_BITS-1:0]);

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      data_next    = data_reg;
      perr_next    = perr_reg;
      valid_next   = 1'b0;
      fcnt_next    = fcnt_reg;
      ecnt_next    = ecnt_reg;

      if (bit_en) begin
         // sync always restarts the frame, discarding any partial one, even on the parity slot
         if (sync) begin
            state_next   = ST_RECV;
            bit_cnt_next = '0;
         end else if (state_reg == ST_RECV) begin
            shift_next   = shift_capture;
            bit_cnt_next = bit_cnt_reg + BC_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
               state_next = ST_IDLE;
               data_next  = shift_capture[DATA_BITS-1:0];
               perr_next  = parity_bad;
               valid_next = 1'b1;
               if (fcnt_reg != '1) begin
                  fcnt_next = fcnt_reg + CNT_W'(1);
               end
               if (parity_bad && (ecnt_reg != '1)) begin
                  ecnt_next = ecnt_reg + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         perr_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         fcnt_reg    <= '0;
         ecnt_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         perr_reg    <= perr_next;
         valid_reg   <= valid_next;
         fcnt_reg    <= fcnt_next;
         ecnt_reg    <= ecnt_next;
      end
   end

   assign data_out    = data_reg;
   assign parity_err  = perr_reg;
   assign valid       = valid_reg;
   assign busy        = (state_reg == ST_RECV);
   assign frame_count = fcnt_reg;
   assign err_count   = ecnt_reg;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: stimulus pushes expected frames into a queue,
// an independent monitor pops and compares each valid pulse.
module tb_serial_parity_rx;

   localparam int DB = 7;
   localparam int CW = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          CLK100MHZ = 1'b0;
   logic          reset     = 1'b1;
   logic          bit_en    = 1'b0;
   logic          sync      = 1'b0;
   logic          serial_in = 1'b0;
   logic [DB-1:0] data_out;
   logic          parity_err;
   logic          valid;
   logic          busy;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] err_count;

   serial_parity_rx #(.DATA_BITS(DB), .CNT_W(CW)) dut (
      .CLK100MHZ  (CLK100MHZ),
      .reset      (reset),
      .bit_en     (bit_en),
      .sync       (sync),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .parity_err (parity_err),
      .valid      (valid),
      .busy       (busy),
      .frame_count(frame_count),
      .err_count  (err_count)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {
      int d;
      int e;
      int fc;
      int ec;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_valid  = 0;
   int   n_pushed = 0;
   int   model_frames = 0;
   int   model_errs   = 0;
   int   extra_gap    = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expected frame.
   always @(negedge CLK100MHZ) begin
      if (!reset && valid) begin
         n_valid++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("frame: data_out=%02h parity_err=%0d frame_count=%0d err_count=%0d (exp %02h %0d %0d %0d)",
                     data_out, parity_err, frame_count, err_count, e.d, e.e, e.fc, e.ec);
            check("data_out", int'(data_out), e.d);
            check("parity_err", int'(parity_err), e.e);
            check("frame_count", int'(frame_count), e.fc);
            check("err_count", int'(err_count), e.ec);
         end
      end
   end

   task automatic send_bit(input logic s, input logic b);
      @(posedge CLK100MHZ); #1;
      sync      = s;
      serial_in = b;
      bit_en    = 1'b1;
      @(posedge CLK100MHZ); #1;
      bit_en    = 1'b0;
      sync      = 1'b0;
      serial_in = 1'($urandom_range(0, 1));
      repeat (extra_gap) @(posedge CLK100MHZ);
   endtask

   task automatic do_reset();
      @(posedge CLK100MHZ); #1;
      reset = 1'b1;
      @(posedge CLK100MHZ); #1;
      reset = 1'b0;
      check("rst_data_out", int'(data_out), 0);
      check("rst_parity_err", int'(parity_err), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_count", int'(frame_count), 0);
      check("rst_err_count", int'(err_count), 0);
      check("rst_sb_empty", sb.size(), 0);
      sb.delete();
      model_frames = 0;
      model_errs   = 0;
   endtask

   // Expected result from the frame's rules: ones in data plus parity must be odd.
   task automatic push_expect(input int data, input int par);
      exp_t e;
      int   ones;
      ones = $countones(data) + par;
      e.d  = data;
      e.e  = (ones % 2 == 0) ? 1 : 0;
      model_frames++;
      model_errs += e.e;
      e.fc = (model_frames > CNT_MAX) ? CNT_MAX : model_frames;
      e.ec = (model_errs > CNT_MAX) ? CNT_MAX : model_errs;
      sb.push_back(e);
      n_pushed++;
   endtask

   task automatic send_frame(input int data, input int par);
      logic [DB-1:0] dv;
      dv = DB'(data);
      send_bit(1'b1, 1'b0);
      check("busy_after_sync", int'(busy), 1);
      for (int i = 0; i < DB; i++) send_bit(1'b0, dv[i]);
      push_expect(data, par);
      send_bit(1'b0, 1'(par));
      check("busy_after_parity", int'(busy), 0);
   endtask

   function automatic int good_parity(input int data);
      return ($countones(data) % 2 == 0) ? 1 : 0;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      repeat (3) @(posedge CLK100MHZ);
      do_reset();

      // Normal frame, then the same data with a bad parity bit
      send_frame('h35, 1);
      do_reset();
      send_frame('h35, 0);

      // Abort: partial frame discarded by a second sync
      do_reset();
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
      send_frame('h0F, 1);

      // Bits with no preceding sync are ignored
      do_reset();
      for (int i = 0; i < 16; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
      check("nosync_busy", int'(busy), 0);
      check("nosync_frame_count", int'(frame_count), 0);
      check("nosync_err_count", int'(err_count), 0);

      // Reset in the middle of a frame
      send_frame('h35, 1);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
      do_reset();
      send_frame('h00, 1);

      // Randomized mix: good/bad frames, aborts (incl. sync on the parity slot), stray bits
      for (int n = 0; n < 40; n++) begin
         int kind;
         int data;
         extra_gap = $urandom_range(0, 3);
         kind = $urandom_range(0, 5);
         data = $urandom_range(0, (1 << DB) - 1);
         if (kind == 4) begin
            int k;
            k = $urandom_range(0, DB);
            send_bit(1'b1, 1'b0);
            for (int i = 0; i < k; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
         end else if (kind == 5) begin
            for (int i = 0; i < $urandom_range(1, 5); i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
         end
         send_frame(data, ($urandom_range(0, 3) == 0) ? 1 - good_parity(data) : good_parity(data));
      end

      // Saturation with bit_en every other cycle
      extra_gap = 0;
      do_reset();
      v0 = n_valid;
      for (int n = 0; n < 260; n++) begin
         int data;
         data = $urandom_range(0, (1 << DB) - 1);
         send_frame(data, good_parity(data));
      end
      repeat (3) @(posedge CLK100MHZ); #1;
      check("sat_frame_count", int'(frame_count), CNT_MAX);
      check("sat_err_count", int'(err_count), 0);
      check("sat_valid_pulses", n_valid - v0, 260);

      repeat (5) @(posedge CLK100MHZ); #1;
      check("sb_drained", sb.size(), 0);
      check("total_valid_pulses", n_valid, n_pushed);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver that sits directly downstream of the odd-parity parallel-to-serial transmitter. It samples one bit per bit-period enable, reassembles an 8-bit frame (7 data bits plus 1 parity bit), checks odd parity, and presents the data word with a one-cycle valid pulse. It also keeps saturating frame and error counters for LED display. Bit timing comes from the same slow-clock generator that paces the transmitter; the block itself runs on the board clock.

## Interface

Parameters:
- DATA_BITS, 7, number of data bits per frame; the frame length is DATA_BITS+1, with parity last.
- CNT_W, 8, width of the frame and error counters.

Ports:
- CLK100MHZ  input  1  board clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  one-cycle pulse per bit period; the block samples inputs only on cycles where bit_en=1.
- sync  input  1  frame sync, high during the transmitter's load period; sampled on bit_en.
- serial_in  input  1  serial data, LSB first, with the parity bit last.
- data_out  output  DATA_BITS  last received data word.
- parity_err  output  1  parity result for the frame in data_out (1 = mismatch).
- valid  output  1  one-cycle pulse when data_out and parity_err update.
- busy  output  1  high while in RECV.
- frame_count  output  CNT_W  completed frames, saturating.
- err_count  output  CNT_W  completed frames with a parity error, saturating.

## Operation

- States:
  - IDLE: waiting for sync.
  - RECV: capturing bits.
- Bit counter is 0..DATA_BITS (4 bits wide for the default).
- Shift register is DATA_BITS+1 bits. Each captured bit is inserted at the MSB and the register shifts right, so the first bit received ends up in bit 0.
- On a bit_en cycle with sync=1, from any state:
  - go to RECV with bit counter = 0; the shift register is not cleared.
  - No bit is captured on this cycle.
  - If the block was already in RECV, the partial frame is discarded silently: no valid, no counter change.
- In RECV, on a bit_en cycle with sync=0:
  - capture serial_in and increment the bit counter.
  - When the captured bit is number DATA_BITS (the parity bit, 8th for the default), the frame is complete: state goes to IDLE on the same edge.
- Frame completion, all on the same edge:
  - data_out <= received bits [DATA_BITS-1:0].
  - parity_err <= (parity bit != ~^data). This is odd parity: the data ones plus the parity bit must total an odd count.
  - valid <= 1.
  - frame_count increments, holding at all-ones.
  - err_count increments if parity_err is set, holding at all-ones.
- In IDLE, a bit_en cycle with sync=0 is ignored. Bits arriving without a preceding sync are never captured.
- Cycles with bit_en=0: no state, counter or data change, except that valid clears.
- Reset (any cycle, including mid-frame) clears the following to 0:
  - state to IDLE
  - bit counter
  - shift register
  - data_out, parity_err, valid, busy
  - frame_count, err_count

## Timing

- All outputs are registered.
- valid is high exactly one CLK100MHZ cycle, on the cycle after the edge that sampled the parity bit. data_out and parity_err change only on that same edge and hold until the next completed frame.
- busy rises on the edge after the sync-sampling bit_en cycle and falls on the frame-completing edge.
- Latency from sync to valid: DATA_BITS+2 bit_en pulses (1 sync + 8 bits for the default), plus 1 clock.
- Simultaneous sync=1 and frame completion on the same bit_en: sync wins. The frame is aborted, nothing is counted, and the block restarts in RECV.
- reset has priority over bit_en and sync in the same cycle.
- There is no constraint on bit_en spacing beyond at least 1 idle clock between pulses. back-to-back pulses every other cycle must work.

## Test plan

- Normal frame: reset, then sync pulse, then bits 1,0,1,0,1,1,0 (data 7'h35), then parity 1 -> valid pulses once, data_out=7'h35, parity_err=0, frame_count=1, err_count=0.
- Parity error: same frame with parity bit 0 -> data_out=7'h35, parity_err=1, frame_count=1, err_count=1.
- Abort: sync, 4 data bits, sync again, then the full 7'h0F frame with parity 1 -> exactly one valid, data_out=7'h0F, parity_err=0, frame_count=1.
- No sync: 16 bit_en pulses with random serial_in and sync=0 from IDLE -> valid never asserts, busy=0, both counters 0.
- Reset mid-frame: assert reset after the 5th data bit, then send a full 7'h00 frame with parity 1 -> all outputs 0 immediately after reset; afterwards data_out=7'h00, parity_err=0, frame_count=1.
- Saturation: 260 good frames -> frame_count=8'hFF and holds; err_count=0; valid still pulses on every frame.
